serdes_frame_aligner: RTL and testbench

Word-boundary and frame-lock controller for the receive side of the 8-bit SerDes link. It takes the MSB-first serial bit stream, hunts for the SYNC byte and confirms frame alignment over several frames. Once locked, it delivers aligned data words with a valid strobe. It sits between the serial input pin and the receive word logic, and it decides when deserialized words are trustworthy.

---
 rtl/serdes_frame_aligner.sv | 184 ++++++++++++++++++
 tb/tb_serdes_frame_aligner.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_frame_aligner.sv
// serdes_frame_aligner
//   Receive-side word-boundary and frame-lock controller for the serial link.
//   It hunts the MSB-first bit stream for SYNC one bit at a time. A candidate
//   alignment is confirmed by LOCK_CNT consecutive syncs, one per frame. While
//   locked it delivers aligned data words. The sync slot is checked every
//   frame, and UNLOCK_CNT consecutive misses drop lock.
//
// Ports
//   clock_in    bit clock, one serial bit per rising edge
//   reset_n     asynchronous active-low reset
//   din         serial data, MSB first
//   enable      bit-valid qualifier; a low cycle is ignored entirely
//   resync      synchronous request to drop alignment and re-hunt
//   dout        last aligned data word
//   dout_valid  one-cycle pulse, dout holds a new data word
//   sync_pulse  one-cycle pulse, correct sync received while locked
//   lock_loss   one-cycle pulse, lock dropped after missed syncs
//   locked      high while in LOCKED
//   state       HUNT=0, VERIFY=1, LOCKED=2
module serdes_frame_aligner #(
    parameter int              WIDTH       = 8,
    parameter int              LOG_WIDTH   = 3,
    parameter logic [WIDTH-1:0] SYNC       = 8'hBC,
    parameter int              FRAME_WORDS = 4,
    parameter int              LOCK_CNT    = 3,
    parameter int              UNLOCK_CNT  = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             din,
    input  logic             enable,
    input  logic             resync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             sync_pulse,
    output logic             lock_loss,
    output logic             locked,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [LOG_WIDTH-1:0] BIT_LAST = LOG_WIDTH'(WIDTH - 1);
    localparam logic [3:0]           IDX_LAST = 4'(FRAME_WORDS - 1);
    localparam logic [3:0]           LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0]           UNLOCK_C = 4'(UNLOCK_CNT);

    state_t               st_q, st_d;
    logic [WIDTH-2:0]     sr_q, sr_d;     // only WIDTH-1 history bits are needed
    logic [LOG_WIDTH-1:0] bit_q, bit_d;
    logic [3:0]           idx_q, idx_d;
    logic [3:0]           good_q, good_d;
    logic [3:0]           miss_q, miss_d;
    logic [WIDTH-1:0]     dout_d;
    logic                 valid_d, sync_d, loss_d, locked_d;

    logic [WIDTH-1:0]     win;
    logic                 boundary;
    logic [3:0]           idx_next;

    assign win      = {sr_q, din};
    assign boundary = (st_q != HUNT) && (bit_q == BIT_LAST);
    assign idx_next = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
    assign state    = st_q;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= HUNT;
            sr_q       <= '0;
            bit_q      <= '0;
            idx_q      <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_pulse <= 1'b0;
            lock_loss  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            st_q       <= st_d;
            sr_q       <= sr_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
            sync_pulse <= sync_d;
            lock_loss  <= loss_d;
            locked     <= locked_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        good_d   = good_q;
        miss_d   = miss_q;
        dout_d   = dout;
        valid_d  = 1'b0;
        sync_d   = 1'b0;
        loss_d   = 1'b0;
        locked_d = locked;

        if (resync) begin
            // Silent re-hunt: no lock_loss, since nothing was missed.
            st_d     = HUNT;
            sr_d     = '0;
            bit_d    = '0;
            idx_d    = '0;
            good_d   = '0;
            miss_d   = '0;
            locked_d = 1'b0;
        end else if (enable) begin
            sr_d = win[WIDTH-2:0];
            case (st_q)
                HUNT: begin
                    if (win == SYNC) begin
                        // The matching sync is the first good one. The next
                        // bit starts word 1 of the frame.
                        st_d     = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                        locked_d = (LOCK_CNT == 1);
                        bit_d    = '0;
                        idx_d    = 4'd1;
                        good_d   = 4'd1;
                        miss_d   = '0;
                    end
                end
                default: begin
                    if (!boundary) begin
                        bit_d = bit_q + 1'b1;
                    end else begin
                        bit_d = '0;
                        idx_d = idx_next;
                        if (idx_q != 4'd0) begin
                            // Data slot: only delivered once alignment is trusted.
                            if (st_q == LOCKED) begin
                                dout_d  = win;
                                valid_d = 1'b1;
                            end
                        end else if (win == SYNC) begin
                            if (st_q == VERIFY) begin
                                good_d = good_q + 4'd1;
                                if (good_q + 4'd1 == LOCK_C) begin
                                    st_d     = LOCKED;
                                    locked_d = 1'b1;
                                    miss_d   = '0;
                                end
                            end else begin
                                sync_d = 1'b1;
                                miss_d = '0;
                            end
                        end else if (st_q == VERIFY) begin
                            // Candidate alignment was wrong; back to bit hunting.
                            st_d   = HUNT;
                            good_d = '0;
                            bit_d  = '0;
                            idx_d  = '0;
                        end else begin
                            // Flywheel: tolerate isolated misses at the sync slot.
                            miss_d = miss_q + 4'd1;
                            if (miss_q + 4'd1 == UNLOCK_C) begin
                                loss_d   = 1'b1;
                                locked_d = 1'b0;
                                st_d     = HUNT;
                                bit_d    = '0;
                                idx_d    = '0;
                                good_d   = '0;
                                miss_d   = '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_frame_aligner.sv
// Self-checking bench for serdes_frame_aligner. The reference model tracks
// alignment as a bit position since the hunt match and derives the frame slot
// arithmetically. Directed scenarios come first, then randomized framed
// traffic with random enable gaps.
module tb_serdes_frame_aligner;

    localparam int          W      = 8;
    localparam int          FW     = 4;
    localparam int          LOCK   = 3;
    localparam int          UNLOCK = 2;
    localparam logic [7:0]  SYNC   = 8'hBC;

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic       din      = 1'b0;
    logic       enable   = 1'b0;
    logic       resync   = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, sync_pulse, lock_loss, locked;
    logic [1:0] state;

    serdes_frame_aligner #(
        .WIDTH(W), .LOG_WIDTH(3), .SYNC(SYNC),
        .FRAME_WORDS(FW), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .din       (din),
        .enable    (enable),
        .resync    (resync),
        .dout      (dout),
        .dout_valid(dout_valid),
        .sync_pulse(sync_pulse),
        .lock_loss (lock_loss),
        .locked    (locked),
        .state     (state)
    );

    always #5 clock_in = ~clock_in;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_st, m_pos, m_good, m_miss;
    logic [7:0] m_hist, m_dout;
    logic       m_valid, m_sync, m_loss, m_locked;

    logic stim[$];

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_good = 0; m_miss = 0;
        m_hist = '0; m_dout = '0;
        m_valid = 0; m_sync = 0; m_loss = 0; m_locked = 0;
    endtask

    task automatic model_step(input logic b, input logic en, input logic rs);
        m_valid = 0; m_sync = 0; m_loss = 0;
        if (rs) begin
            m_st = 0; m_hist = '0; m_pos = 0; m_good = 0; m_miss = 0; m_locked = 0;
            return;
        end
        if (!en) return;
        m_hist = {m_hist[6:0], b};
        if (m_st == 0) begin
            if (m_hist == SYNC) begin
                m_good = 1; m_miss = 0; m_pos = 0;
                m_st = (LOCK == 1) ? 2 : 1;
                m_locked = (m_st == 2);
            end
            return;
        end
        if (m_pos % W == W - 1) begin
            int slot;
            slot = (m_pos / W + 1) % FW;
            if (slot != 0) begin
                if (m_st == 2) begin m_dout = m_hist; m_valid = 1; end
            end else if (m_hist == SYNC) begin
                if (m_st == 1) begin
                    m_good++;
                    if (m_good == LOCK) begin m_st = 2; m_locked = 1; m_miss = 0; end
                end else begin
                    m_sync = 1; m_miss = 0;
                end
            end else if (m_st == 1) begin
                m_st = 0; m_good = 0;
            end else begin
                m_miss++;
                if (m_miss == UNLOCK) begin
                    m_loss = 1; m_locked = 0; m_st = 0; m_good = 0; m_miss = 0;
                end
            end
        end
        if (m_st != 0) m_pos++;
        else m_pos = 0;
    endtask

    function automatic logic [13:0] observed();
        return {state, locked, lock_loss, sync_pulse, dout_valid, dout};
    endfunction

    function automatic logic [13:0] expected();
        return {2'(m_st), m_locked, m_loss, m_sync, m_valid, m_dout};
    endfunction

    task automatic drive(input logic b, input logic en, input logic rs);
        din = b; enable = en; resync = rs;
        @(posedge clock_in);
        model_step(b, en, rs);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) stim.push_back(v[i]);
    endtask

    task automatic push_frames(input int n, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c);
        for (int f = 0; f < n; f++) begin
            push_byte(SYNC); push_byte(a); push_byte(b); push_byte(c);
        end
    endtask

    task automatic test_reset();
        int nvalid = 0;
        reset_n = 1'b0; din = 1'b0; enable = 1'b0; resync = 1'b0;
        model_reset();
        repeat (3) @(posedge clock_in);
        #1;
        checks++;
        if (observed() !== 14'h0) $display("FAIL reset_state: got %h expected %h", observed(), 14'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h expected %h", i, observed(), expected());
            end
            if (dout_valid) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin errors++; $display("FAIL reset_no_valid: got %0d expected 0", nvalid); end
    endtask

    task automatic test_lock();
        logic [7:0] got[$];
        int vidx[$];
        int nsync = 0;
        logic [7:0] want[6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
        stim.delete();
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
        push_frames(4, 8'h11, 8'h22, 8'h33);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL lock cyc %0d: got %h expected %h", i, observed(), expected());
            end
            if (dout_valid) begin got.push_back(dout); vidx.push_back(i); end
            if (sync_pulse) nsync++;
            if (i == 3 + 7) begin
                checks++;
                if (state !== 2'd1) begin errors++; $display("FAIL lock_verify_entry: got %0d expected 1", state); end
            end
            if (i == 3 + 64 + 7) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL lock_third_sync: got %b expected 1", locked); end
            end
        end
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL lock_data_count: got %0d expected 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (got[k] !== want[k]) begin
                    errors++; $display("FAIL lock_data[%0d]: got %h expected %h", k, got[k], want[k]);
                end
            end
            checks++;
            if (vidx[1] - vidx[0] != 8) begin
                errors++; $display("FAIL lock_spacing: got %0d expected 8", vidx[1] - vidx[0]);
            end
        end
        checks++;
        if (nsync !== 1) begin errors++; $display("FAIL lock_sync_pulse: got %0d expected 1", nsync); end
    endtask

    task automatic test_flywheel();
        int nvalid = 0, nloss = 0;
        stim.delete();
        push_byte(8'hBD); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        push_byte(8'hBC); push_byte(8'h44); push_byte(8'h55); push_byte(8'h66);
        push_byte(8'hBD); push_byte(8'h77); push_byte(8'h88); push_byte(8'h99);
        push_byte(8'hBD);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL flywheel cyc %0d: got %h expected %h", i, observed(), expected());
            end
            if (dout_valid) nvalid++;
            if (lock_loss) nloss++;
        end
        checks++;
        if ({lock_loss, state, locked} !== 4'b1_00_0) begin
            errors++;
            $display("FAIL flywheel_loss: got loss=%b state=%0d locked=%b expected 1 0 0", lock_loss, state, locked);
        end
        checks++;
        if (nvalid !== 9 || nloss !== 1) begin
            errors++; $display("FAIL flywheel_counts: got valid=%0d loss=%0d expected 9 1", nvalid, nloss);
        end
    endtask

    task automatic test_verify_fail();
        logic saw_lock = 0;
        stim.delete();
        push_byte(8'hBC); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h00);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL verify cyc %0d: got %h expected %h", i, observed(), expected());
            end
            if (locked) saw_lock = 1;
            if (i == 38) begin
                checks++;
                if (state !== 2'd1) begin errors++; $display("FAIL verify_held: got %0d expected 1", state); end
            end
        end
        checks++;
        if (state !== 2'd0 || saw_lock !== 1'b0) begin
            errors++; $display("FAIL verify_drop: got state=%0d lock_seen=%b expected 0 0", state, saw_lock);
        end
    endtask

    task automatic test_enable_stall();
        logic [7:0] w = 8'h5A;
        int k = 0, vat = -1;
        logic [7:0] vdata = '0;
        stim.delete();
        push_frames(3, 8'h11, 8'h22, 8'h33);
        push_byte(SYNC);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL stall_pre cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        for (int j = 7; j >= 0; j--) begin
            if (j == 3) begin
                for (int s = 0; s < 5; s++) begin
                    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                    k++;
                    checks++;
                    if (observed() !== expected()) begin
                        errors++; $display("FAIL stall_gap %0d: got %h expected %h", s, observed(), expected());
                    end
                end
            end
            drive(w[j], 1'b1, 1'b0);
            k++;
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL stall_word bit %0d: got %h expected %h", j, observed(), expected());
            end
            if (dout_valid) begin vat = k; vdata = dout; end
        end
        checks++;
        if (vat !== 13 || vdata !== 8'h5A) begin
            errors++; $display("FAIL stall_delay: got at=%0d data=%h expected 13 5a", vat, vdata);
        end
        stim.delete();
        push_byte(8'h22); push_byte(8'h33);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL stall_post cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_resync();
        int nvalid = 0;
        stim.delete();
        push_byte(SYNC);
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL resync_pre cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL resync_locked_before: got %b expected 1", locked); end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if ({state, locked, lock_loss} !== 4'b00_0_0) begin
            errors++;
            $display("FAIL resync_drop: got state=%0d locked=%b loss=%b expected 0 0 0", state, locked, lock_loss);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL resync_post cyc %0d: got %h expected %h", i, observed(), expected());
            end
            if (dout_valid) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin errors++; $display("FAIL resync_no_valid: got %0d expected 0", nvalid); end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b1);
        stim.delete();
        push_frames(3, 8'h11, 8'h22, 8'h33);
        push_byte(SYNC);
        stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b0);
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL areset_pre cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL areset_locked_before: got %b expected 1", locked); end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (observed() !== 14'h0) begin
            errors++; $display("FAIL areset_immediate: got %h expected %h", observed(), 14'h0);
        end
        @(posedge clock_in);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL areset_post cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        int i = 0;
        logic saw_lock = 0;
        int nvalid = 0;
        stim.delete();
        for (int j = 0; j < int'($urandom_range(0, 7)); j++) stim.push_back(1'($urandom_range(0, 1)));
        for (int f = 0; f < 40; f++) begin
            push_byte(($urandom_range(0, 9) != 0) ? SYNC : 8'($urandom_range(0, 255)));
            for (int d = 1; d < FW; d++) push_byte(8'($urandom_range(0, 255)));
        end
        while (i < stim.size()) begin
            logic en;
            en = ($urandom_range(0, 7) != 0);
            drive(en ? stim[i] : 1'($urandom_range(0, 1)), en, 1'b0);
            if (en) i++;
            checks++;
            if (observed() !== expected()) begin
                errors++; $display("FAIL random bit %0d: got %h expected %h", i, observed(), expected());
            end
            if (locked) saw_lock = 1;
            if (dout_valid) nvalid++;
        end
        checks++;
        if (saw_lock !== 1'b1 || nvalid == 0) begin
            errors++; $display("FAIL random_activity: got lock_seen=%b valid=%0d expected 1 and >0", saw_lock, nvalid);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flywheel();
        test_verify_fail();
        test_enable_stall();
        test_resync();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
